// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, instr}
// with registered-only ready/valid and a single-cycle flush for redirects.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [63:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [63:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;

  // Handshakes look only at registered occupancy, so a same-cycle pop never
  // frees room for a push and there is no ready-to-ready combinational path.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[head];
  assign out_instr = instr_mem[head];

  assign push = in_valid  && in_ready  && !flush && !reset;
  assign pop  = out_valid && out_ready && !flush && !reset;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Each cycle it accepts one fetched instruction: its pc (64 bit) and raw instruction word (32 bit). Entries are stored in a small circular FIFO and presented to decode in program order. This decouples fetch from decode back-pressure. A branch redirect drops every queued instruction in one cycle.

## Interface
- DEPTH, 4, number of entries; must be a power of two and ≥ 2
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  branch redirect; discards all entries and this cycle's push
- in_valid  in  1  fetch offers an instruction this cycle
- in_pc  in  64  pc of the offered instruction
- in_instr  in  32  raw instruction word
- in_ready  out  1  queue can accept; push happens when in_valid && in_ready
- out_valid  out  1  head entry is valid
- out_pc  out  64  pc of the head entry
- out_instr  out  32  instruction of the head entry
- out_ready  in  1  decode consumes the head; pop happens when out_valid && out_ready
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH entries of {pc, instr}.
- Pointers: head and tail, each $clog2(DEPTH) bits, wrap modulo DEPTH. A separate occupancy counter holds 0..DEPTH.
- Push: write {in_pc, in_instr} at tail; tail advances by 1.
- Pop: head advances by 1. Entry contents are not cleared.
- empty = (count == 0); full = (count == DEPTH).
- in_ready = !full. It depends only on registered state. Room freed by a same-cycle pop is not offered, so there is no ready→ready combinational path.
- out_valid = !empty. out_pc and out_instr always show the entry at head. Their values are don't-care when out_valid = 0.
- count next-state:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged. Both pointers advance.
- Push and pop in the same cycle with count == 1:
  - the old head is popped;
  - the new entry becomes the head next cycle;
  - out_valid stays 1.
- Flush:
  - next cycle head = tail = 0 and count = 0;
  - any push or pop in the flush cycle is ignored;
  - in_ready and out_valid are not masked during the flush cycle. Decode must itself ignore a head presented in the same cycle as flush.
- Priority: reset > flush > push/pop.
- No bypass: an instruction pushed into an empty queue is visible at the output the following cycle.

## Timing
- Reset values, one cycle after reset is sampled high:
  - head = 0, tail = 0, count = 0
  - out_valid = 0, in_ready = 1
  - out_pc and out_instr don't-care. The storage array is not reset.
- Latency:
  - push at edge N: out_valid = 1 after edge N with that entry at head, unless older entries remain.
  - Minimum in→out latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH−1.
- Full: in_ready = 0 for the entire cycle. A pop that cycle makes in_ready = 1 the next cycle.
- Empty: out_ready is ignored and no underflow occurs. When full, in_valid is ignored and no overflow occurs.
- Pointer wrap: after DEPTH pushes the tail returns to 0. Order is preserved across the wrap.
- Reset or flush mid-stream: queue is empty the next cycle. The first push afterwards lands at index 0.

## Test plan
- After reset, push pcs 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C with instrs 0x00000013..0x00000016, out_ready = 0:
  - count reaches 4 and in_ready = 0;
  - a fifth push of 0x8000_0010 is rejected;
  - then out_ready = 1 drains in order 0x8000_0000…0x8000_000C, and out_valid drops after the 4th pop.
- Streaming: in_valid = 1 and out_ready = 1 for 20 cycles with pc incrementing by 4:
  - count holds at 1 after the first cycle;
  - out_pc each cycle equals the in_pc of the previous cycle;
  - this exercises pointer wrap 3→0 several times.
- Full with simultaneous pop: count = 4, out_ready = 1, in_valid = 1 with pc 0x8000_0100:
  - in_ready = 0, so no push;
  - next cycle count = 3 and in_ready = 1.
- Flush with 3 entries, in_valid = 1 and out_ready = 1 in the same cycle:
  - next cycle count = 0 and out_valid = 0;
  - a push of 0x8000_0200 is at head one cycle later and is the only entry.
- Reset asserted while 2 entries are queued and a push is offered:
  - next cycle count = 0, out_valid = 0, in_ready = 1;
  - reset has priority even if flush is also high.
- Random valid/ready (10k cycles) against a reference queue model:
  - pc/instr order and count match exactly;
  - no push is accepted while full and no pop occurs while empty.
